// File: rtl/follow_seq.sv
// follow_seq: command sequencer for the line-follower steering loop.
// Takes station commands from the UART path and barcode IDs from the reader,
// and enables the PID block (go) until the destination station is read or the
// line has been lost for too long. Sounds the piezo while the line is lost.
//
// Ports:
//   clk           system clock (50 MHz)
//   rst           asynchronous active-high reset
//   cmd[7:0]      command byte: [7:6] opcode (00 stop, 01 go), [5:0] station
//   cmd_rdy       command valid, held until cleared
//   clr_cmd_rdy   clear of cmd_rdy, combinational (high whenever cmd_rdy is high)
//   ID[7:0]       barcode byte: [7:6] must be 00, [5:0] station
//   ID_vld        barcode valid, held until cleared
//   clr_ID_vld    clear of ID_vld, combinational (high whenever ID_vld is high)
//   line_present  line sensor sees the line
//   go            enable to PID / forward speed, decoded from state register
//   buzz, buzz_n  complementary piezo drive, active only when lost
//   dest[5:0]     latched destination station
module follow_seq #(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    input  logic       line_present,
    output logic       go,
    output logic       buzz,
    output logic       buzz_n,
    output logic [5:0] dest
);

    localparam int unsigned TMR_W = 26;
    localparam int unsigned DIV_W = 14;
    localparam int unsigned STN_W = 6;

    // Timeout fires when the lost timer reaches TMAX-1.
    localparam logic [TMR_W-1:0] TMR_LIM = FAST_SIM ? TMR_W'(4095) : {TMR_W{1'b1}};

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FOLLOW = 2'b01,
        LOST   = 2'b10
    } state_t;

    state_t             state, state_n;
    logic [STN_W-1:0]   dest_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [DIV_W-1:0]   div, div_n;

    logic go_cmd_c, stop_cmd_c, id_match_c, timeout_c;

    // Request decode; illegal opcodes (1x) match neither stop nor go.
    assign go_cmd_c   = cmd_rdy && (cmd[7:6] == OP_GO);
    assign stop_cmd_c = cmd_rdy && (cmd[7:6] == OP_STOP);
    assign id_match_c = ID_vld && (ID[7:6] == 2'b00) && (ID[5:0] == dest);
    assign timeout_c  = (state == FOLLOW) && (timer == TMR_LIM);

    // Ready flags are cleared whenever seen, regardless of state.
    assign clr_cmd_rdy = cmd_rdy;
    assign clr_ID_vld  = ID_vld;

    // Next-state, destination, lost timer and buzzer divider.
    always_comb begin
        state_n = state;
        dest_n  = dest;
        timer_n = '0;
        div_n   = '0;
        unique case (state)
            IDLE: begin
                if (go_cmd_c) begin
                    dest_n  = cmd[5:0];
                    state_n = FOLLOW;
                end
            end
            FOLLOW: begin
                if (timeout_c) begin
                    state_n = LOST;
                end else if (stop_cmd_c) begin
                    state_n = IDLE;
                end else if (go_cmd_c) begin
                    // Reload dest; an ID in the same cycle is compared against
                    // the old dest and therefore ignored.
                    dest_n = cmd[5:0];
                end else if (id_match_c) begin
                    state_n = IDLE;
                end else if (!line_present) begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            LOST: begin
                div_n = div + DIV_W'(1);
                if (go_cmd_c) begin
                    dest_n  = cmd[5:0];
                    state_n = FOLLOW;
                end else if (stop_cmd_c) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dest  <= '0;
            timer <= '0;
            div   <= '0;
        end else begin
            state <= state_n;
            dest  <= dest_n;
            timer <= timer_n;
            div   <= div_n;
        end
    end

    // Outputs decoded from registers only, so reset drops them immediately.
    assign go     = (state == FOLLOW);
    assign buzz   = (state == LOST) &&  div[DIV_W-1];
    assign buzz_n = (state == LOST) && !div[DIV_W-1];

endmodule

// File: tb/tb_follow_seq.sv
// Directed bench for follow_seq with FAST_SIM=1 (TMAX = 4096).
module tb_follow_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;
    logic       line_present;
    logic       go;
    logic       buzz;
    logic       buzz_n;
    logic [5:0] dest;

    int n_vec = 0;
    int n_err = 0;

    follow_seq #(.FAST_SIM(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .ID           (ID),
        .ID_vld       (ID_vld),
        .clr_ID_vld   (clr_ID_vld),
        .line_present (line_present),
        .go           (go),
        .buzz         (buzz),
        .buzz_n       (buzz_n),
        .dest         (dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        logic       cmd_rdy;
        logic [7:0] id;
        logic       id_vld;
        logic       lp;
        logic       e_clr_cmd;
        logic       e_clr_id;
        logic       e_go;
        logic [5:0] e_dest;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic cr, input logic [7:0] i,
                         input logic iv, input logic lp);
        cmd          = c;
        cmd_rdy      = cr;
        ID           = i;
        ID_vld       = iv;
        line_present = lp;
    endtask

    initial begin
        logic ok;

        //           cmd    rdy   id     vld   lp    clrc  clri  go    dest
        vecs[0]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00};
        vecs[1]  = '{8'h45, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h05};
        vecs[2]  = '{8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h05};
        vecs[3]  = '{8'h00, 1'b0, 8'h45, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h05};
        vecs[4]  = '{8'h00, 1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h05};
        vecs[5]  = '{8'h00, 1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h05};
        vecs[6]  = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h05};
        vecs[7]  = '{8'h45, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h05};
        vecs[8]  = '{8'h80, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h05};
        vecs[9]  = '{8'hC0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h05};
        vecs[10] = '{8'h00, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h05};
        vecs[11] = '{8'h45, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h05};
        vecs[12] = '{8'h4A, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h0A};
        vecs[13] = '{8'h4A, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h0A};
        vecs[14] = '{8'h00, 1'b0, 8'h0A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h0A};
        vecs[15] = '{8'h80, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h0A};
        vecs[16] = '{8'h47, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h07};
        vecs[17] = '{8'h00, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h07};

        rst = 1'b1;
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        #12;
        check("rst_go",     32'(go),     32'h0);
        check("rst_buzz",   32'(buzz),   32'h0);
        check("rst_buzz_n", 32'(buzz_n), 32'h0);
        check("rst_dest",   32'(dest),   32'h0);
        check("rst_clr",    32'({clr_cmd_rdy, clr_ID_vld}), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Table of single-cycle transactions.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].cmd, vecs[i].cmd_rdy, vecs[i].id, vecs[i].id_vld, vecs[i].lp);
            #1;
            check($sformatf("v%0d_clr_cmd", i), 32'(clr_cmd_rdy), 32'(vecs[i].e_clr_cmd));
            check($sformatf("v%0d_clr_id", i),  32'(clr_ID_vld),  32'(vecs[i].e_clr_id));
            tick();
            check($sformatf("v%0d_go", i),   32'(go),   32'(vecs[i].e_go));
            check($sformatf("v%0d_dest", i), 32'(dest), 32'(vecs[i].e_dest));
        end

        // Timeout, with stop + matching ID arriving on the timeout edge.
        drive(8'h45, 1'b1, 8'h00, 1'b0, 1'b1);
        tick();
        check("to1_go_entry", 32'(go), 32'h1);
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 4095; i++) begin
            tick();
            if (go !== 1'b1) ok = 1'b0;
        end
        check("to1_go_held", 32'(ok), 32'h1);
        drive(8'h00, 1'b1, 8'h05, 1'b1, 1'b0);
        #1;
        check("to1_clrs", 32'({clr_cmd_rdy, clr_ID_vld}), 32'h3);
        tick();
        check("to1_go_low",  32'(go),     32'h0);
        check("to1_lost",    32'(buzz_n), 32'h1);
        check("to1_buzz0",   32'(buzz),   32'h0);
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Buzzer half-period of 8192 cycles.
        ok = 1'b1;
        for (int i = 0; i < 8191; i++) begin
            tick();
            if (buzz !== 1'b0 || buzz_n !== 1'b1) ok = 1'b0;
        end
        check("buzz_low_phase", 32'(ok), 32'h1);
        tick();
        check("buzz_rise",   32'({buzz, buzz_n}), 32'h2);
        ok = 1'b1;
        for (int i = 0; i < 8191; i++) begin
            tick();
            if (buzz !== 1'b1 || buzz_n !== 1'b0) ok = 1'b0;
        end
        check("buzz_high_phase", 32'(ok), 32'h1);
        tick();
        check("buzz_fall",   32'({buzz, buzz_n}), 32'h1);

        // Go from LOST.
        drive(8'h47, 1'b1, 8'h00, 1'b0, 1'b1);
        tick();
        check("lost_go",      32'(go),   32'h1);
        check("lost_go_dest", 32'(dest), 32'h07);
        check("lost_go_buzz", 32'({buzz, buzz_n}), 32'h0);
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-FOLLOW.
        #2;
        rst = 1'b1;
        #1;
        check("arst_f_go",   32'(go),   32'h0);
        check("arst_f_dest", 32'(dest), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_f_idle", 32'({go, buzz, buzz_n}), 32'h0);

        // Timeout restarted by a one-cycle line_present pulse.
        drive(8'h45, 1'b1, 8'h00, 1'b0, 1'b1);
        tick();
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) tick();
        line_present = 1'b1;
        tick();
        line_present = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4095; i++) begin
            tick();
            if (go !== 1'b1) ok = 1'b0;
        end
        check("to2_go_held", 32'(ok), 32'h1);
        tick();
        check("to2_lost", 32'({go, buzz_n}), 32'h1);

        // Stop from LOST.
        drive(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        tick();
        check("lost_stop", 32'({go, buzz, buzz_n}), 32'h0);
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("lost_stop_idle", 32'({go, buzz, buzz_n}), 32'h0);

        // Asynchronous reset mid-LOST.
        drive(8'h45, 1'b1, 8'h00, 1'b0, 1'b0);
        tick();
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4096; i++) tick();
        check("to3_lost", 32'({go, buzz_n}), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_l_out", 32'({go, buzz, buzz_n}), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_l_dest", 32'(dest), 32'h0);
        check("arst_l_idle", 32'({go, buzz, buzz_n}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/follow_seq.md
# follow_seq

Command sequencer for the line-follower steering loop. It accepts station commands from the UART command path and barcode IDs from the barcode reader, and drives the `go` enable into the PID steering block. It stops `go` when the destination station is read or the line is lost for too long, and sounds the piezo buzzer when the line is lost. It sits between the command/barcode receivers and the PID/motor datapath in the follower top level.

## Interface

Parameters:
- FAST_SIM, 0, when 1 the line-lost timeout shrinks from 2^26 to 2^12 cycles for simulation.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset; asynchronous, active-high; one clock; reset is asynchronous and active-high
- cmd  in  8  command byte; [7:6] opcode (00 stop, 01 go), [5:0] destination station
- cmd_rdy  in  1  cmd valid; held by the receiver until cleared
- clr_cmd_rdy  out  1  one-cycle clear of cmd_rdy
- ID  in  8  barcode byte; [7:6] must be 00 for a valid station, [5:0] station number
- ID_vld  in  1  ID valid; held until cleared
- clr_ID_vld  out  1  one-cycle clear of ID_vld
- line_present  in  1  line sensor reports a line under the robot
- go  out  1  enable to the PID/forward-speed logic
- buzz  out  1  piezo drive
- buzz_n  out  1  complementary piezo drive
- dest  out  6  currently latched destination station

## Operation

- Reset state: state=IDLE, dest=0, lost timer=0, buzz divider=0. Outputs go=0, buzz=0, buzz_n=0, clr_cmd_rdy=0, clr_ID_vld=0.
- State machine has three states: IDLE, FOLLOW and LOST.
- `go` is 1 only in FOLLOW and is decoded from the state register.
- `clr_cmd_rdy` is 1 in any cycle where `cmd_rdy`=1. It is decoded combinationally and is independent of state.
- `clr_ID_vld` is 1 in any cycle where `ID_vld`=1, in any state.
- Opcodes 10 and 11 are illegal. They are cleared and have no other effect.
- IDLE:
  - Go command (cmd[7:6]=01): latch dest←cmd[5:0], clear the timer, go to FOLLOW.
  - Stop command: remain in IDLE.
  - `ID_vld` and `line_present` are ignored.
- FOLLOW, evaluated in priority order:
  - (1) Timeout reached: go to LOST.
  - (2) Stop command: go to IDLE.
  - (3) Go command: reload dest, clear the timer, stay in FOLLOW.
  - (4) `ID_vld` with ID[7:6]=00 and ID[5:0]=dest: go to IDLE.
  - (5) Any other ID: ignored, but still cleared.
- LOST:
  - Go command: latch dest, clear the timer, go to FOLLOW.
  - Stop command: go to IDLE.
  - IDs are cleared and ignored.
- Lost timer (26 bits):
  - Increments each cycle in FOLLOW while `line_present`=0.
  - Clears when `line_present`=1, or in any state other than FOLLOW.
  - Timeout fires when timer = TMAX−1, where TMAX = FAST_SIM ? 4096 : 67,108,864.
- Buzzer:
  - A 14-bit free-running divider runs only in LOST and clears outside LOST.
  - In LOST, buzz = divider[13] and buzz_n = ~divider[13], giving about 3.05 kHz at 50 MHz.
  - Outside LOST, buzz=0 and buzz_n=0.
- Asserting rst mid-operation forces the reset state immediately; `go` drops without waiting for a clock edge.

## Timing

- Command latency: `cmd_rdy` sampled high at edge N causes `go` to change after edge N. `clr_cmd_rdy` is high in the cycle before edge N.
- ID match: `go` falls after the edge where the matching `ID_vld` is sampled.
- Timeout: `line_present` low continuously from edge k causes `go` to fall after edge k+TMAX−1. A single cycle of `line_present`=1 restarts the count from 0.
- Simultaneous events in FOLLOW:
  - Timeout wins over any command or ID. Both ready flags are still cleared.
  - Stop command plus a matching ID gives IDLE.
  - Go command to station S plus an ID equal to the old dest: stay in FOLLOW with dest=S. The ID is compared against the old dest only after the command and is ignored.
- A `cmd_rdy` that stays high for multiple cycles (receiver has not yet cleared) is re-evaluated each cycle. Repeated go commands are idempotent.

## Test plan

- Reset then cmd=8'h45 with cmd_rdy=1 for 1 cycle -> clr_cmd_rdy=1 that cycle; next cycle go=1, dest=6'h05.
- While in FOLLOW with dest=5: ID=8'h03 -> clr_ID_vld pulse, go stays 1. Then ID=8'h05 -> go=0 the next cycle, state IDLE. Also ID=8'h45 -> ignored.
- FAST_SIM=1, FOLLOW, line_present=0 for 4095 cycles -> go=1 throughout. At cycle 4096 go=0 and buzz toggles every 8192 cycles with buzz_n=~buzz. Repeat with line_present=1 pulsed at cycle 4000 -> no timeout.
- In LOST: cmd=8'h47 -> go=1, dest=7, buzz=buzz_n=0. Separately, cmd=8'h00 -> IDLE, buzz off.
- In FOLLOW: cmd=8'h00 and matching ID asserted in the same cycle -> both clears pulse, go=0. Separately, cmd=8'h80 -> cleared, no state change.
- Assert rst asynchronously mid-FOLLOW and mid-LOST -> go, buzz, buzz_n fall immediately. After release, the state is IDLE with dest=0.
